// File: rtl/core_ifu_queue.sv
// Instruction fetch unit: PC generation, in-order memory requests and a DEPTH-entry
// prefetch queue feeding decode, with jump flush and stale-response dropping.
module core_ifu_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     jump_flag_in,
  input  logic [ADDR_W-1:0]        jump_addr_in,
  input  logic                     hold_flag_in,
  output logic                     req_valid_out,
  output logic [ADDR_W-1:0]        req_addr_out,
  input  logic                     req_ready_in,
  input  logic                     resp_valid_in,
  input  logic [INST_W-1:0]        resp_data_in,
  output logic                     inst_valid_out,
  output logic [INST_W-1:0]        inst_out,
  output logic [ADDR_W-1:0]        inst_addr_out,
  input  logic                     inst_ready_in,
  output logic [$clog2(DEPTH):0]   level_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [INST_W-1:0] NOP = INST_W'(32'h0000_0013);

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_q_addr [DEPTH];
  logic [INST_W-1:0] r_q_inst [DEPTH];
  logic [ADDR_W-1:0] r_tag    [DEPTH];
  logic [PW-1:0]     r_rd_ptr, r_wr_ptr, r_tag_rd, r_tag_wr;
  logic [CW-1:0]     r_count, r_outstanding, r_drop;

  logic w_credit, w_req_fire, w_resp_ok, w_resp_stale, w_enq, w_deq;
  logic w_unused_jump_lsb;

  assign w_unused_jump_lsb = ^jump_addr_in[1:0];

  // Credit counts stale requests too, so every response always has a queue slot.
  assign w_credit      = ({1'b0, r_count} + {1'b0, r_outstanding}) < (CW+1)'(DEPTH);
  assign req_valid_out = rst & ~jump_flag_in & w_credit;
  assign req_addr_out  = r_fetch_pc;
  assign w_req_fire    = req_valid_out & req_ready_in;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_resp_ok    = resp_valid_in & (r_outstanding != '0);
  assign w_resp_stale = w_resp_ok & (r_drop != '0);
  assign w_enq        = w_resp_ok & ~w_resp_stale & ~jump_flag_in;

  assign inst_valid_out = (r_count != '0);
  assign w_deq          = inst_valid_out & inst_ready_in & ~hold_flag_in & ~jump_flag_in;
  assign inst_out       = inst_valid_out ? r_q_inst[r_rd_ptr] : NOP;
  assign inst_addr_out  = inst_valid_out ? r_q_addr[r_rd_ptr] : '0;
  assign level_out      = r_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fetch_pc    <= RESET_PC;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_tag_rd      <= '0;
      r_tag_wr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else if (jump_flag_in) begin
      r_fetch_pc    <= {jump_addr_in[ADDR_W-1:2], 2'b00};
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_tag_rd      <= '0;
      r_tag_wr      <= '0;
      r_count       <= '0;
      r_outstanding <= r_outstanding - CW'(w_resp_ok);
      r_drop        <= r_outstanding - CW'(w_resp_ok);
    end else begin
      if (w_req_fire) begin
        r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
        r_tag_wr   <= r_tag_wr + 1'b1;
      end
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_tag_rd <= r_tag_rd + 1'b1;
      end
      if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_resp_stale) r_drop <= r_drop - 1'b1;
      r_count       <= r_count + CW'(w_enq) - CW'(w_deq);
      r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_resp_ok);
    end
  end

  // Payload storage needs no reset; validity comes from the counters above.
  always_ff @(posedge clk) begin
    if (w_req_fire) r_tag[r_tag_wr] <= r_fetch_pc;
    if (rst && w_enq) begin
      r_q_addr[r_wr_ptr] <= r_tag[r_tag_rd];
      r_q_inst[r_wr_ptr] <= resp_data_in;
    end
  end

endmodule

// File: tb/tb_core_ifu_queue.sv
// Randomized bench for core_ifu_queue: a latency-configurable memory and a queue-level
// reference model of the fetch queue, in-flight requests and redirect behaviour.
module tb_core_ifu_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        jump_flag_in = 1'b0;
  logic [31:0] jump_addr_in = '0;
  logic        hold_flag_in = 1'b0;
  logic        req_valid_out;
  logic [31:0] req_addr_out;
  logic        req_ready_in = 1'b0;
  logic        resp_valid_in = 1'b0;
  logic [31:0] resp_data_in = '0;
  logic        inst_valid_out;
  logic [31:0] inst_out;
  logic [31:0] inst_addr_out;
  logic        inst_ready_in = 1'b0;
  logic [2:0]  level_out;

  core_ifu_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .jump_flag_in(jump_flag_in), .jump_addr_in(jump_addr_in), .hold_flag_in(hold_flag_in),
    .req_valid_out(req_valid_out), .req_addr_out(req_addr_out), .req_ready_in(req_ready_in),
    .resp_valid_in(resp_valid_in), .resp_data_in(resp_data_in),
    .inst_valid_out(inst_valid_out), .inst_out(inst_out), .inst_addr_out(inst_addr_out),
    .inst_ready_in(inst_ready_in), .level_out(level_out)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; bit stale; } infl_t;
  typedef struct { logic [31:0] addr; int due; } mem_t;

  // Reference model: delivered-queue of addresses, in-flight request list, next PC.
  logic [31:0] m_q[$];
  infl_t       m_infl[$];
  logic [31:0] m_pc;
  // Memory environment.
  mem_t        mem_q[$];
  logic [31:0] fire_log[$];
  int          lat = 1;
  int          last_due = -1;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic cycle(input bit jmp, input logic [31:0] ja, input bit hold,
                       input bit rdy, input bit mrdy);
    bit          exp_rv, m_fire, deq, got;
    int          due;
    infl_t       r;
    mem_t        m;
    logic [31:0] head;
    @(negedge clk);
    jump_flag_in  = jmp;
    jump_addr_in  = ja;
    hold_flag_in  = hold;
    inst_ready_in = rdy;
    req_ready_in  = mrdy;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      resp_valid_in = 1'b1;
      resp_data_in  = mem_data(mem_q[0].addr);
    end else begin
      resp_valid_in = 1'b0;
      resp_data_in  = '0;
    end
    #1;
    exp_rv = !jmp && (m_q.size() + m_infl.size() < DEPTH);
    check_val("req_valid", 32'(req_valid_out), 32'(exp_rv));
    if (exp_rv) check_val("req_addr", req_addr_out, m_pc);
    head = (m_q.size() > 0) ? m_q[0] : 32'h0;
    check_val("inst_valid", 32'(inst_valid_out), 32'(m_q.size() > 0));
    check_val("inst_addr", inst_addr_out, head);
    check_val("inst", inst_out, (m_q.size() > 0) ? mem_data(head) : NOP);
    check_val("level", 32'(level_out), 32'(m_q.size()));

    // Model update for the coming edge.
    m_fire = exp_rv && mrdy;
    deq    = (m_q.size() > 0) && rdy && !hold && !jmp;
    got    = 1'b0;
    if (resp_valid_in && m_infl.size() > 0) begin
      r   = m_infl.pop_front();
      got = !jmp && !r.stale;
    end
    if (jmp) begin
      m_q.delete();
      foreach (m_infl[i]) m_infl[i].stale = 1'b1;
      m_pc = {ja[31:2], 2'b00};
    end else begin
      if (deq) void'(m_q.pop_front());
      if (got) m_q.push_back(r.addr);
      if (m_fire) begin
        m_infl.push_back('{addr: m_pc, stale: 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end

    // Memory side, driven by what the DUT actually did.
    if (resp_valid_in) void'(mem_q.pop_front());
    if (req_valid_out && req_ready_in) begin
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      m.addr = req_addr_out;
      m.due  = due;
      mem_q.push_back(m);
      fire_log.push_back(req_addr_out);
    end
    cyc++;
  endtask

  initial begin
    int idx;
    int f0;
    m_pc = RST_PC;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_req_valid", 32'(req_valid_out), 32'd0);
    check_val("rst_inst_valid", 32'(inst_valid_out), 32'd0);
    check_val("rst_inst", inst_out, NOP);
    check_val("rst_inst_addr", inst_addr_out, 32'h0);
    check_val("rst_level", 32'(level_out), 32'd0);
    rst = 1'b1;

    // Boot with wrap-around, then fill the queue with no consumer.
    lat = 1;
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check_val("boot_req0", fire_log[0], 32'hFFFF_FFF8);
    check_val("boot_req1", fire_log[1], 32'hFFFF_FFFC);
    check_val("boot_req2", fire_log[2], 32'h0000_0000);
    repeat (5) cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check_val("bp_fires", 32'(fire_log.size()), 32'd4);
    check_val("bp_level", 32'(level_out), 32'd4);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
    f0 = fire_log.size();
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check_val("bp_level_after_deq", 32'(level_out), 32'd3);
    repeat (5) cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check_val("bp_one_new_req", 32'(fire_log.size() - f0), 32'd1);

    // Hold with queue holding 0x200.. then release.
    cycle(1'b1, 32'h200, 1'b0, 1'b0, 1'b1);
    repeat (6) cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    repeat (4) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
    check_val("hold_head", inst_addr_out, 32'h200);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
    check_val("rel_head0", inst_addr_out, 32'h200);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
    check_val("rel_head1", inst_addr_out, 32'h204);

    // Jump with stale in-flight responses, L=3.
    lat = 3;
    cycle(1'b1, 32'h300, 1'b0, 1'b0, 1'b1);
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'h403, 1'b0, 1'b0, 1'b1);
    idx = fire_log.size();
    repeat (3) begin
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
      check_val("stale_level", 32'(level_out), 32'd0);
    end
    repeat (5) cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
    if (fire_log.size() > idx) check_val("jump_first_req", fire_log[idx], 32'h400);
    else check_val("jump_first_req_seen", 32'(fire_log.size() - idx), 32'd1);

    // Steady stream, then jump coincident with response and dequeue.
    lat = 2;
    repeat (10) cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 32'h500, 1'b0, 1'b1, 1'b1);
    repeat (10) cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);

    // Random traffic with varying latency.
    for (int ph = 0; ph < 4; ph++) begin
      lat = $urandom_range(1, 4);
      for (int k = 0; k < 100; k++)
        cycle($urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 3) == 0,
              1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/core_ifu_queue.md
# core_ifu_queue

Parametrised instruction-fetch unit that merges PC generation, fetch and IF/ID buffering into one block with a DEPTH-entry prefetch queue. It sits between the instruction memory and core_id. It issues in-order requests over a valid/ready memory port that tolerates multi-cycle latency. It flushes on a jump from core_ctrl, drops stale in-flight responses, and stalls delivery on hold.

## Interface
- ADDR_W, 32, instruction address width
- INST_W, 32, instruction width
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 0, first fetch address after reset; bits [1:0] must be 0
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-low
- jump_flag_in  in  1  redirect request from core_ctrl
- jump_addr_in  in  ADDR_W  redirect target; bits [1:0] ignored (forced 0)
- hold_flag_in  in  1  pipeline hold; blocks dequeue
- req_valid_out  out  1  fetch request valid
- req_addr_out  out  ADDR_W  fetch address
- req_ready_in  in  1  memory accepts request
- resp_valid_in  in  1  response valid; always accepted, in request order
- resp_data_in  in  INST_W  fetched instruction
- inst_valid_out  out  1  queue head valid
- inst_out  out  INST_W  head instruction; 32'h00000013 (NOP) when empty
- inst_addr_out  out  ADDR_W  head instruction address; 0 when empty
- inst_ready_in  in  1  consumer takes head this cycle
- level_out  out  clog2(DEPTH)+1  current queue occupancy

## Operation
- State:
  - fetch_pc
  - FIFO of {addr, inst} pairs with rd_ptr/wr_ptr/count
  - `outstanding`: accepted requests with no response yet, 0..DEPTH
  - `drop`: stale in-flight responses, 0..outstanding
  - a small address FIFO (DEPTH entries) tagging each outstanding request with its PC
- Request issue:
  - req_valid_out = rst & ~jump_flag_in & (count + outstanding < DEPTH).
  - This credit check guarantees every response has a slot, so the queue can never overflow.
  - req_fire = req_valid_out & req_ready_in.
  - On req_fire: fetch_pc += 4 (wraps modulo 2^ADDR_W) and push fetch_pc into the tag FIFO.
- Response:
  - On resp_valid_in with drop>0: discard and decrement drop.
  - Otherwise: pop the tag FIFO and write {tag, resp_data_in} to the queue.
  - Every response decrements outstanding.
  - A resp_valid_in while outstanding==0 is a protocol error. It is ignored and must never be generated by the bench.
- Dequeue:
  - deq = inst_valid_out & inst_ready_in & ~hold_flag_in & ~jump_flag_in.
  - Enqueue and dequeue in the same cycle leave count unchanged, including when the queue is full.
- Jump (jump_flag_in=1 at an edge), highest priority:
  - Clear the queue: count=0, pointers reset.
  - fetch_pc ← {jump_addr_in[ADDR_W-1:2], 2'b00}.
  - drop ← outstanding − resp_valid_in, so all remaining in-flight requests are stale.
  - Any response arriving in the jump cycle is discarded. No dequeue occurs.
  - Tag FIFO is cleared; stale responses do not pop it.
- Reset (rst=0 at an edge), overrides jump:
  - fetch_pc=RESET_PC; count, outstanding and drop = 0.
  - Queue outputs return to their empty values.
  - Responses still in flight at reset are the memory's responsibility. The memory must also be reset.
- Simultaneous events:
  - jump + hold: jump wins.
  - hold + full queue: requests stop by credit, and no response is lost.

## Timing
- Values during and after reset:
  - req_valid_out=0 while rst=0; =1 in the first cycle after rst rises.
  - inst_valid_out=0, inst_out=32'h00000013, inst_addr_out=0, level_out=0.
- req_addr_out = fetch_pc, combinational from register; stable while req_valid_out & ~req_ready_in.
- Fetch latency:
  - Request accepted at edge N; memory responds at edge N+L (L≥1).
  - inst_valid_out rises in the cycle after the response edge. There is no response-to-output bypass.
- Minimum redirect penalty: jump at edge J → first request to the target in cycle J+1 → instruction at output no earlier than J+1+L+1.
- Sustained throughput: one instruction per cycle when DEPTH ≥ L+1 and the consumer is always ready.
- inst_out, inst_addr_out and level_out are registered or head-indexed. They change only at clock edges.

## Test plan
- **Reset/boot:** hold rst=0 for 3 cycles with RESET_PC=0x100, then release, with memory L=1 always ready.
  - Requests go to 0x100, 0x104, 0x108 on consecutive cycles.
  - inst_addr_out=0x100 is valid 2 cycles after the first request.
- **Full-queue backpressure:** DEPTH=4, inst_ready_in=0.
  - req_valid_out drops after exactly 4 requests; level_out=4.
  - Raising inst_ready_in for 1 cycle yields level_out=3 and exactly one new request.
- **Hold:** hold_flag_in=1 with inst_ready_in=1 and the queue holding 0x200/0x204.
  - The head stays at 0x200 for the whole hold.
  - On release, 0x200 then 0x204 are delivered on successive cycles.
- **Jump with in-flight stale responses:** L=3 memory, 3 requests outstanding, then jump to 0x403.
  - The next 3 responses are discarded and level_out stays 0.
  - The first request after the jump is to 0x400.
  - The first delivered inst_addr_out is 0x400.
- **Jump coincident with a response and a dequeue:** level_out resets to 0 and drop = outstanding−1. No instruction from before the jump is ever delivered.
- **Wrap-around:** ADDR_W=32 with RESET_PC=0xFFFFFFF8.
  - Requests go to 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
  - Queue pointer wrap is checked over ≥3·DEPTH instructions with random ready and hold, comparing against a reference model.
